adder2bit_faulty: RTL and testbench

ADDER2BIT_FAULTY -- requirements
Module: adder2bit_faulty

---
 rtl/adder2bit_faulty_pkg.sv | 21 ++
 rtl/adder2bit_faulty_full_adder.sv | 19 +
 rtl/adder2bit_faulty.sv | 108 ++++++++++
 tb/tb_adder2bit_faulty.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/adder2bit_faulty_pkg.sv
// Purpose : shared encodings for the stuck-at fault-injection adder.
// Latency : n/a (constants only).
// Backpressure: n/a.
//
// Site numbers select which internal net of the faulty adder is forced.
// Fault types give the value the selected net is forced to.
package adder2bit_faulty_pkg;

  localparam int unsigned SITE_A0   = 0;
  localparam int unsigned SITE_A1   = 1;
  localparam int unsigned SITE_B0   = 2;
  localparam int unsigned SITE_B1   = 3;
  localparam int unsigned SITE_S0   = 4;
  localparam int unsigned SITE_C0   = 5;
  localparam int unsigned SITE_S1   = 6;
  localparam int unsigned SITE_COUT = 7;

  localparam int unsigned SA0 = 0;
  localparam int unsigned SA1 = 1;

endpackage

// File: rtl/adder2bit_faulty_full_adder.sv
// Purpose : 1-bit combinational full adder cell.
// Latency : 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   a_i, b_i, cin_i : operand bits and carry in
//   s_o, cout_o     : sum bit and carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/adder2bit_faulty.sv
// Purpose : 2-bit adder with a stuck-at fault injectable on one net, compared against a golden sum.
// Latency : 1 cycle from a/b/fault_en to sum/sum_ref/mismatch/err_cnt.
// Backpressure: none; a new operand pair is accepted every cycle.
//
// Ports:
//   clk, rst_n        : clock (rising edge) and synchronous active-low reset
//   a, b              : 2-bit unsigned addends
//   fault_en          : 1 forces the net selected by FAULT_SITE to FAULT_TYPE
//   sum               : registered result of the faulty ripple-carry path
//   sum_ref           : registered golden result a+b
//   mismatch          : registered flag, sum != sum_ref
//   err_cnt           : saturating count of mismatching cycles since reset
module adder2bit_faulty
  import adder2bit_faulty_pkg::*;
#(
  parameter int unsigned FAULT_SITE = SITE_S0,
  parameter int unsigned FAULT_TYPE = SA0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       fault_en,
  output logic [2:0] sum,
  output logic [2:0] sum_ref,
  output logic       mismatch,
  output logic [7:0] err_cnt
);

  // Illegal parameter values stop elaboration rather than silently injecting nothing.
  if (FAULT_SITE > SITE_COUT) begin : g_bad_site
    $error("adder2bit_faulty: FAULT_SITE must be 0..7");
  end
  if (FAULT_TYPE > SA1) begin : g_bad_type
    $error("adder2bit_faulty: FAULT_TYPE must be 0 or 1");
  end

  localparam logic FVAL = (FAULT_TYPE == SA1);

  // Faulty datapath: each exposed net passes through a mux that substitutes
  // the stuck value, so every consumer downstream sees the forced value.
  logic a0_f, a1_f, b0_f, b1_f;
  logic s0_raw, c0_raw, s1_raw, cout_raw;
  logic s0_f, c0_f, s1_f, cout_f;

  assign a0_f = (fault_en && FAULT_SITE == SITE_A0) ? FVAL : a[0];
  assign a1_f = (fault_en && FAULT_SITE == SITE_A1) ? FVAL : a[1];
  assign b0_f = (fault_en && FAULT_SITE == SITE_B0) ? FVAL : b[0];
  assign b1_f = (fault_en && FAULT_SITE == SITE_B1) ? FVAL : b[1];

  full_adder u_fa0 (
    .a_i    (a0_f),
    .b_i    (b0_f),
    .cin_i  (1'b0),
    .s_o    (s0_raw),
    .cout_o (c0_raw)
  );

  assign s0_f = (fault_en && FAULT_SITE == SITE_S0) ? FVAL : s0_raw;
  assign c0_f = (fault_en && FAULT_SITE == SITE_C0) ? FVAL : c0_raw;

  full_adder u_fa1 (
    .a_i    (a1_f),
    .b_i    (b1_f),
    .cin_i  (c0_f),
    .s_o    (s1_raw),
    .cout_o (cout_raw)
  );

  assign s1_f   = (fault_en && FAULT_SITE == SITE_S1)   ? FVAL : s1_raw;
  assign cout_f = (fault_en && FAULT_SITE == SITE_COUT) ? FVAL : cout_raw;

  // Next-state values. The golden path always sees the untouched operands.
  logic [2:0] sum_d, sum_ref_d, sum_q, sum_ref_q;
  logic       mismatch_d, mismatch_q;
  logic [7:0] err_cnt_d, err_cnt_q;

  always_comb begin
    sum_d      = {cout_f, s1_f, s0_f};
    sum_ref_d  = {1'b0, a} + {1'b0, b};
    // Derived from next-state values so the flag lines up with the pair it describes.
    mismatch_d = (sum_d != sum_ref_d);
    err_cnt_d  = err_cnt_q;
    if (mismatch_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q      <= 3'd0;
      sum_ref_q  <= 3'd0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      sum_q      <= sum_d;
      sum_ref_q  <= sum_ref_d;
      mismatch_q <= mismatch_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign sum      = sum_q;
  assign sum_ref  = sum_ref_q;
  assign mismatch = mismatch_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_adder2bit_faulty.sv
// Directed bench for adder2bit_faulty: default instance (s0 stuck-at-0) plus
// a second instance with the bit-0 carry stuck-at-1, sharing the same stimulus.
module tb_adder2bit_faulty;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] a, b;
  logic       fault_en;

  logic [2:0] sum, sum_ref, sum2, sum_ref2;
  logic       mismatch, mismatch2;
  logic [7:0] err_cnt, err_cnt2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  adder2bit_faulty dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .fault_en (fault_en),
    .sum      (sum),
    .sum_ref  (sum_ref),
    .mismatch (mismatch),
    .err_cnt  (err_cnt)
  );

  adder2bit_faulty #(.FAULT_SITE(5), .FAULT_TYPE(1)) dut_c0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .fault_en (fault_en),
    .sum      (sum2),
    .sum_ref  (sum_ref2),
    .mismatch (mismatch2),
    .err_cnt  (err_cnt2)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] av, input logic [1:0] bv, input logic fe);
    a        = av;
    b        = bv;
    fault_en = fe;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    logic [2:0] ref_v, exp_sum;

    rst_n = 1'b0;
    drive(2'd3, 2'd3, 1'b1);
    tick();
    tick();
    check("rst_sum",      8'(sum),      8'd0);
    check("rst_sum_ref",  8'(sum_ref),  8'd0);
    check("rst_mismatch", 8'(mismatch), 8'd0);
    check("rst_err_cnt",  err_cnt,      8'd0);
    check("rst_sum2",     8'(sum2),     8'd0);

    // Fault disabled: 3+1.
    rst_n = 1'b1;
    drive(2'd3, 2'd1, 1'b0);
    tick();
    check("nofault_sum",      8'(sum),      8'd4);
    check("nofault_sum_ref",  8'(sum_ref),  8'd4);
    check("nofault_mismatch", 8'(mismatch), 8'd0);
    check("nofault_err_cnt",  err_cnt,      8'd0);

    // s0 stuck-at-0: 1+2=3 reads as 2.
    drive(2'd1, 2'd2, 1'b1);
    tick();
    check("s0sa0_sum",      8'(sum),      8'd2);
    check("s0sa0_sum_ref",  8'(sum_ref),  8'd3);
    check("s0sa0_mismatch", 8'(mismatch), 8'd1);
    check("s0sa0_err_cnt",  err_cnt,      8'd1);

    // 2+2=4 has s0=0 naturally, so the fault is masked.
    drive(2'd2, 2'd2, 1'b1);
    tick();
    check("masked_sum",      8'(sum),      8'd4);
    check("masked_mismatch", 8'(mismatch), 8'd0);
    check("masked_err_cnt",  err_cnt,      8'd1);

    // c0 stuck-at-1 instance: 0+0 becomes 2.
    drive(2'd0, 2'd0, 1'b1);
    tick();
    check("c0sa1_sum",      8'(sum2),      8'd2);
    check("c0sa1_sum_ref",  8'(sum_ref2),  8'd0);
    check("c0sa1_mismatch", 8'(mismatch2), 8'd1);
    check("c0sa1_dflt_sum", 8'(sum),       8'd0);

    // Exhaustive sweep against a simple model for the default instance.
    exp_cnt = 8'd1;
    for (int fe = 0; fe < 2; fe++) begin
      for (int ai = 0; ai < 4; ai++) begin
        for (int bi = 0; bi < 4; bi++) begin
          drive(2'(ai), 2'(bi), 1'(fe));
          tick();
          ref_v   = 3'(ai + bi);
          exp_sum = (fe == 1 && ref_v[0]) ? ref_v - 3'd1 : ref_v;
          if (exp_sum != ref_v) exp_cnt = exp_cnt + 8'd1;
          check($sformatf("sweep_sum fe=%0d a=%0d b=%0d", fe, ai, bi), 8'(sum), 8'(exp_sum));
          check($sformatf("sweep_ref fe=%0d a=%0d b=%0d", fe, ai, bi), 8'(sum_ref), 8'(ref_v));
          check($sformatf("sweep_mm fe=%0d a=%0d b=%0d", fe, ai, bi), 8'(mismatch), 8'(exp_sum != ref_v));
          check($sformatf("sweep_cnt fe=%0d a=%0d b=%0d", fe, ai, bi), err_cnt, exp_cnt);
        end
      end
    end

    // Hold a mismatching vector long enough to saturate the counter.
    drive(2'd1, 2'd0, 1'b1);
    for (int i = 0; i < 300; i++) tick();
    check("sat_err_cnt",  err_cnt,      8'd255);
    check("sat_mismatch", 8'(mismatch), 8'd1);
    for (int i = 0; i < 10; i++) tick();
    check("sat_hold_err_cnt", err_cnt, 8'd255);

    // One reset edge mid-stream clears everything.
    rst_n = 1'b0;
    tick();
    check("mid_rst_sum",      8'(sum),      8'd0);
    check("mid_rst_sum_ref",  8'(sum_ref),  8'd0);
    check("mid_rst_mismatch", 8'(mismatch), 8'd0);
    check("mid_rst_err_cnt",  err_cnt,      8'd0);
    check("mid_rst_err_cnt2", err_cnt2,     8'd0);

    // First edge after release counts from zero.
    rst_n = 1'b1;
    tick();
    check("post_rst_sum",     8'(sum), 8'd0);
    check("post_rst_err_cnt", err_cnt, 8'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
